uart_sys_ctrl: RTL and testbench
================================

// Module: uart_sys_ctrl
// PURPOSE
//  Command sequencer behind the UART receiver: parses byte frames from the RX path into register-file
//  write/read transactions and returns read data through the UART TX handshake.
//  Sits between UART_RX (data_valid/P_DATA), the system register file and the UART TX input.
// PARAMETERS
//  DATA_W          8     byte width of RX, TX and register-file data
//  ADDR_W          4     register-file address width; the address byte is truncated to its low ADDR_W bits
//  TIMEOUT_CYCLES  1023  inter-byte timeout in clk cycles (used only with UART_SYS_CTRL_TIMEOUT_EN)
// PORTS
//  clk         in   1       system clock
//  rst         in   1       asynchronous, active-high reset
//  rx_data     in   DATA_W  received byte, qualified by rx_valid
//  rx_valid    in   1       one-cycle pulse per received good byte
//  rf_addr     out  ADDR_W  register-file address
//  rf_wr_data  out  DATA_W  register-file write data
//  rf_wr_en    out  1       one-cycle write strobe
//  rf_rd_en    out  1       one-cycle read strobe
//  rf_rd_data  in   DATA_W  read data, qualified by rf_rd_valid
//  rf_rd_valid in   1       read-data-valid pulse, any cycle after rf_rd_en
//  tx_data     out  DATA_W  byte to transmit, stable while tx_valid=1
//  tx_valid    out  1       TX request; held until accepted
//  tx_busy     in   1       TX busy; transfer occurs on a cycle with tx_valid=1 and tx_busy=0
//  cmd_error   out  1       one-cycle pulse on a protocol error
//  ctrl_busy   out  1       1 whenever state != IDLE
// BEHAVIOUR
//  - All outputs are registered and reset to 0; reset forces IDLE from any state, mid-frame included.
//  - Opcodes: WR_CMD=0xAA followed by addr, data; RD_CMD=0xBB followed by addr.
//  - States and transitions:
//    IDLE:
//      rx 0xAA -> WR_ADDR; rx 0xBB -> RD_ADDR
//      any other byte -> cmd_error pulse, stay IDLE
//    WR_ADDR: rx -> capture rf_addr, go to WR_DATA
//    WR_DATA: rx -> capture rf_wr_data, go to WR_EXEC
//    WR_EXEC: rf_wr_en=1 for exactly 1 cycle -> IDLE
//      (strobe is asserted the cycle after the data byte's rx_valid)
//    RD_ADDR: rx -> capture rf_addr, go to RD_REQ
//    RD_REQ:  rf_rd_en=1 for 1 cycle -> RD_WAIT
//    RD_WAIT: rf_rd_valid -> capture tx_data, go to TX_SEND
//      (rf_rd_valid in the same cycle as rf_rd_en is ignored)
//    TX_SEND:
//      tx_valid=1; on tx_valid && !tx_busy -> tx_valid=0 next cycle, go to IDLE
//      tx_data holds until the transfer
//  - rx_valid in RD_REQ, RD_WAIT, TX_SEND or WR_EXEC: byte dropped, cmd_error pulse, state unaffected.
//  - Back-to-back frames: a new opcode is accepted from the first IDLE cycle; no bubble beyond WR_EXEC.
//  - rf_addr and rf_wr_data hold their last values when idle.
// CONFIGURATION
//  - UART_SYS_CTRL_TIMEOUT_EN defined:
//    - A counter clears on every rx_valid and counts in WR_ADDR, WR_DATA and RD_ADDR.
//    - Reaching TIMEOUT_CYCLES -> IDLE with a cmd_error pulse; the partial frame is discarded.
//    - If rx_valid coincides with the terminal count, the byte wins and no error is raised.
//    - Counter width: $clog2(TIMEOUT_CYCLES+1).
//  - Undefined: no counter; a partial frame waits indefinitely (only reset aborts it).
// STRUCTURE
//  - Package uart_sys_pkg: state enum sys_state_e, opcode localparams WR_CMD/RD_CMD.
//  - Single module: state register, next-state logic, registered outputs and the optional timeout counter
//    inline. No sub-module.
// TESTING
//  1. Write frame: rx AA,03,5C -> one rf_wr_en pulse with rf_addr=3, rf_wr_data=0x5C,
//     1 cycle after the 0x5C rx_valid; cmd_error=0.
//  2. Read frame:
//     - stimulus: rx BB,07; rf_rd_valid with 0xA1 three cycles after rf_rd_en; tx_busy=1 for 5 cycles
//     - response: tx_valid held with tx_data=0xA1 through busy; transfer once busy drops; then IDLE
//  3. Bad opcode: rx 0x12 in IDLE -> cmd_error pulse; no rf strobes; ctrl_busy stays 0.
//  4. Overrun: rx 0x55 while in RD_WAIT -> cmd_error pulse; the read still completes with the correct tx_data.
//  5. Reset mid-frame:
//     - stimulus: rx AA,02, then rst pulse, then rx 0x99
//     - response: no rf_wr_en; outputs 0 after reset; 0x99 treated as bad opcode -> cmd_error
//  6. Timeout (UART_SYS_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16):
//     - rx AA then silence -> IDLE with cmd_error after 16 cycles
//     - a byte arriving exactly at the terminal count is accepted

Source files
------------

// File: rtl/uart_sys_pkg.sv
// Shared types and opcodes for the UART command sequencer.
package uart_sys_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_WR_EXEC,
        ST_RD_ADDR,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_TX_SEND
    } sys_state_e;

    localparam logic [7:0] WR_CMD = 8'hAA;
    localparam logic [7:0] RD_CMD = 8'hBB;

endpackage

// File: rtl/uart_sys_ctrl.sv
// Parses UART RX byte frames into register-file writes/reads and returns read data to UART TX.
// Optional inter-byte timeout enabled by defining UART_SYS_CTRL_TIMEOUT_EN.
module uart_sys_ctrl
    import uart_sys_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              rf_wr_en,
    output logic              rf_rd_en,
    input  logic [DATA_W-1:0] rf_rd_data,
    input  logic              rf_rd_valid,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_busy,
    output logic              cmd_error,
    output logic              ctrl_busy
);

    sys_state_e        state_q, state_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0] rf_wr_data_q, rf_wr_data_d;
    logic              rf_wr_en_q, rf_wr_en_d;
    logic              rf_rd_en_q, rf_rd_en_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              cmd_error_q, cmd_error_d;
    logic              ctrl_busy_q, ctrl_busy_d;

`ifdef UART_SYS_CTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

    always_comb begin
        state_d      = state_q;
        rf_addr_d    = rf_addr_q;
        rf_wr_data_d = rf_wr_data_q;
        rf_wr_en_d   = 1'b0;
        rf_rd_en_d   = 1'b0;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        cmd_error_d  = 1'b0;

        // Strobes are computed one state early so the registered pulse lines up with EXEC/REQ.
        unique case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == DATA_W'(WR_CMD))      state_d = ST_WR_ADDR;
                    else if (rx_data == DATA_W'(RD_CMD)) state_d = ST_RD_ADDR;
                    else                                 cmd_error_d = 1'b1;
                end
            end
            ST_WR_ADDR: begin
                if (rx_valid) begin
                    rf_addr_d = rx_data[ADDR_W-1:0];
                    state_d   = ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                if (rx_valid) begin
                    rf_wr_data_d = rx_data;
                    rf_wr_en_d   = 1'b1;
                    state_d      = ST_WR_EXEC;
                end
            end
            ST_WR_EXEC: begin
                cmd_error_d = rx_valid;
                state_d     = ST_IDLE;
            end
            ST_RD_ADDR: begin
                if (rx_valid) begin
                    rf_addr_d  = rx_data[ADDR_W-1:0];
                    rf_rd_en_d = 1'b1;
                    state_d    = ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                cmd_error_d = rx_valid;
                state_d     = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                cmd_error_d = rx_valid;
                if (rf_rd_valid) begin
                    tx_data_d  = rf_rd_data;
                    tx_valid_d = 1'b1;
                    state_d    = ST_TX_SEND;
                end
            end
            ST_TX_SEND: begin
                cmd_error_d = rx_valid;
                if (tx_valid_q && !tx_busy) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef UART_SYS_CTRL_TIMEOUT_EN
        // A byte on the terminal-count cycle takes priority over the timeout.
        tmo_cnt_d = '0;
        if ((state_q == ST_WR_ADDR || state_q == ST_WR_DATA || state_q == ST_RD_ADDR) && !rx_valid) begin
            if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                state_d     = ST_IDLE;
                cmd_error_d = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
            end
        end
`endif

        ctrl_busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rf_addr_q    <= '0;
            rf_wr_data_q <= '0;
            rf_wr_en_q   <= 1'b0;
            rf_rd_en_q   <= 1'b0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            cmd_error_q  <= 1'b0;
            ctrl_busy_q  <= 1'b0;
`ifdef UART_SYS_CTRL_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            rf_addr_q    <= rf_addr_d;
            rf_wr_data_q <= rf_wr_data_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_rd_en_q   <= rf_rd_en_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            cmd_error_q  <= cmd_error_d;
            ctrl_busy_q  <= ctrl_busy_d;
`ifdef UART_SYS_CTRL_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end

    assign rf_addr    = rf_addr_q;
    assign rf_wr_data = rf_wr_data_q;
    assign rf_wr_en   = rf_wr_en_q;
    assign rf_rd_en   = rf_rd_en_q;
    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign cmd_error  = cmd_error_q;
    assign ctrl_busy  = ctrl_busy_q;

endmodule

// File: tb/tb_uart_sys_ctrl.sv
// Scoreboard bench for uart_sys_ctrl: directed frames push expected strobes/transfers/errors,
// a negedge monitor pops and compares them. Define UART_SYS_CTRL_TIMEOUT_EN to add the timeout cases.
module tb_uart_sys_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [3:0] rf_addr;
    logic [7:0] rf_wr_data;
    logic       rf_wr_en;
    logic       rf_rd_en;
    logic [7:0] rf_rd_data;
    logic       rf_rd_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_busy;
    logic       cmd_error;
    logic       ctrl_busy;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_exp_t;

    wr_exp_t    wr_q[$];
    logic [3:0] rd_q[$];
    logic [7:0] tx_q[$];
    bit         err_q[$];

    int         checks = 0;
    int         errors = 0;
    logic [7:0] rd_resp = 8'h00;

    uart_sys_ctrl #(
        .DATA_W(8),
        .ADDR_W(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rf_addr(rf_addr),
        .rf_wr_data(rf_wr_data),
        .rf_wr_en(rf_wr_en),
        .rf_rd_en(rf_rd_en),
        .rf_rd_data(rf_rd_data),
        .rf_rd_valid(rf_rd_valid),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_busy(tx_busy),
        .cmd_error(cmd_error),
        .ctrl_busy(ctrl_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got an event, required none", name);
    endtask

    // One-cycle rx_valid pulse, driven just after a rising edge.
    task automatic applyStimulus(input logic [7:0] b);
        @(posedge clk);
        #1 rx_data = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        for (int i = 0; i < budget && ctrl_busy; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("ctrl_busy_idle", {31'd0, ctrl_busy}, 32'd0);
    endtask

    task automatic waitTxValid(input int budget);
        for (int i = 0; i < budget && !tx_valid; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("tx_valid_rise", {31'd0, tx_valid}, 32'd1);
    endtask

    // Register-file model: answers each read strobe three cycles later with rd_resp.
    initial begin
        rf_rd_valid = 1'b0;
        rf_rd_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (rf_rd_en && !rst) begin
                repeat (3) @(posedge clk);
                #1 rf_rd_valid = 1'b1;
                rf_rd_data = rd_resp;
                @(posedge clk);
                #1 rf_rd_valid = 1'b0;
            end
        end
    end

    // Monitor: every DUT output event is matched against the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (rf_wr_en) begin
                if (wr_q.size() == 0) unexpected("wr_strobe");
                else begin
                    wr_exp_t e;
                    e = wr_q.pop_front();
                    checkOutput("wr_addr", {28'd0, rf_addr}, {28'd0, e.addr});
                    checkOutput("wr_data", {24'd0, rf_wr_data}, {24'd0, e.data});
                end
            end
            if (rf_rd_en) begin
                if (rd_q.size() == 0) unexpected("rd_strobe");
                else begin
                    logic [3:0] a;
                    a = rd_q.pop_front();
                    checkOutput("rd_addr", {28'd0, rf_addr}, {28'd0, a});
                end
            end
            if (tx_valid && !tx_busy) begin
                if (tx_q.size() == 0) unexpected("tx_transfer");
                else begin
                    logic [7:0] d;
                    d = tx_q.pop_front();
                    checkOutput("tx_data", {24'd0, tx_data}, {24'd0, d});
                end
            end
            if (cmd_error) begin
                if (err_q.size() == 0) unexpected("cmd_error");
                else void'(err_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] bad_ops [4];
        bad_ops[0] = 8'h12;
        bad_ops[1] = 8'h00;
        bad_ops[2] = 8'hFF;
        bad_ops[3] = 8'hAB;

        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_busy  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_outputs",
            {5'd0, rf_addr, rf_wr_data, rf_wr_en, rf_rd_en, tx_data, tx_valid, cmd_error, ctrl_busy},
            32'd0);
        rst = 1'b0;

        // Write frame: strobe appears exactly one cycle after the data byte.
        wr_q.push_back('{addr: 4'h3, data: 8'h5C});
        applyStimulus(8'hAA);
        applyStimulus(8'h03);
        applyStimulus(8'h5C);
        checkOutput("wr_strobe_timing", {31'd0, rf_wr_en}, 32'd1);
        checkOutput("busy_in_exec", {31'd0, ctrl_busy}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("wr_strobe_single", {31'd0, rf_wr_en}, 32'd0);
        checkOutput("idle_after_wr", {31'd0, ctrl_busy}, 32'd0);
        checkOutput("wr_data_hold", {24'd0, rf_wr_data}, 32'h5C);

        // Back-to-back frame with an address byte wider than the register file.
        wr_q.push_back('{addr: 4'hF, data: 8'hFF});
        applyStimulus(8'hAA);
        applyStimulus(8'h3F);
        applyStimulus(8'hFF);
        waitIdle(10);

        // Read frame with TX held busy for five cycles.
        rd_resp = 8'hA1;
        tx_busy = 1'b1;
        rd_q.push_back(4'h7);
        tx_q.push_back(8'hA1);
        applyStimulus(8'hBB);
        applyStimulus(8'h07);
        waitTxValid(20);
        for (int i = 0; i < 5; i++) begin
            checkOutput("tx_hold_valid", {31'd0, tx_valid}, 32'd1);
            checkOutput("tx_hold_data", {24'd0, tx_data}, 32'hA1);
            @(posedge clk);
            #1;
        end
        tx_busy = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("tx_valid_drop", {31'd0, tx_valid}, 32'd0);
        checkOutput("idle_after_rd", {31'd0, ctrl_busy}, 32'd0);

        // Bad opcodes in IDLE.
        for (int i = 0; i < 4; i++) begin
            err_q.push_back(1'b1);
            applyStimulus(bad_ops[i]);
            @(posedge clk);
            #1;
            checkOutput("bad_op_not_busy", {31'd0, ctrl_busy}, 32'd0);
        end

        // Overrun while waiting for read data; the read still completes.
        rd_resp = 8'h3C;
        rd_q.push_back(4'h4);
        tx_q.push_back(8'h3C);
        applyStimulus(8'hBB);
        applyStimulus(8'h04);
        err_q.push_back(1'b1);
        applyStimulus(8'h55);
        waitIdle(20);

        // Reset mid-frame: the partial write is discarded.
        applyStimulus(8'hAA);
        applyStimulus(8'h02);
        @(negedge clk);
        rst = 1'b1;
        #2;
        checkOutput("midframe_reset_outputs",
            {5'd0, rf_addr, rf_wr_data, rf_wr_en, rf_rd_en, tx_data, tx_valid, cmd_error, ctrl_busy},
            32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        err_q.push_back(1'b1);
        applyStimulus(8'h99);
        @(posedge clk);
        #1;
        checkOutput("after_reset_idle", {31'd0, ctrl_busy}, 32'd0);

`ifdef UART_SYS_CTRL_TIMEOUT_EN
        // Silence after an opcode times out after 16 cycles.
        err_q.push_back(1'b1);
        applyStimulus(8'hAA);
        repeat (15) @(posedge clk);
        #1;
        checkOutput("tmo_still_busy", {31'd0, ctrl_busy}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("tmo_to_idle", {31'd0, ctrl_busy}, 32'd0);

        // A byte landing on the terminal count is accepted.
        wr_q.push_back('{addr: 4'h5, data: 8'h77});
        applyStimulus(8'hAA);
        repeat (14) @(posedge clk);
        applyStimulus(8'h05);
        applyStimulus(8'h77);
        waitIdle(10);
`endif

        repeat (5) @(posedge clk);
        #1;
        checkOutput("wr_q_drained", wr_q.size(), 32'd0);
        checkOutput("rd_q_drained", rd_q.size(), 32'd0);
        checkOutput("tx_q_drained", tx_q.size(), 32'd0);
        checkOutput("err_q_drained", err_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
